// File: rtl/keypad_msg_writer.sv
// Keypad scanner with debounce feeding a 10-character message buffer for a
// scrolling 7-segment display. Newest character sits in msg[4:0]; 5'h1F is blank.
module keypad_msg_writer #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  input  logic        clear,
  output logic [49:0] msg,
  output logic [3:0]  msg_len,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        full
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One spare bit so the incremented count never wraps before the compare.
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 2);
  localparam logic [49:0] Blank = '1;

  typedef enum logic [1:0] {StScan, StDebounce, StRelease} state_e;

  state_e          r_state;
  logic [DivW-1:0] r_div;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      r_row;
  logic [1:0]      r_row_idx;
  logic [1:0]      r_col_idx;
  logic            r_key_valid;
  logic [3:0]      r_key_code;
  logic [49:0]     r_msg;
  logic [3:0]      r_msg_len;

  logic            w_tick;
  logic            w_any_low;
  logic [1:0]      w_low_idx;
  logic            w_same_low;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_cnt_done;
  logic            w_accept;
  logic [3:0]      w_code;

  assign w_tick     = (r_div == DivW'(SCAN_DIV - 1));
  assign w_any_low  = (col_in != 4'hF);
  assign w_same_low = ~col_in[r_col_idx];
  assign w_cnt_inc  = r_cnt + CntW'(1);
  assign w_cnt_done = (w_cnt_inc >= CntW'(DEBOUNCE_CNT));
  assign w_accept   = (r_state == StDebounce) && w_tick && w_same_low && w_cnt_done;

  // Lowest-index low column wins when several are pressed.
  always_comb begin
    w_low_idx = 2'd3;
    if (!col_in[0])      w_low_idx = 2'd0;
    else if (!col_in[1]) w_low_idx = 2'd1;
    else if (!col_in[2]) w_low_idx = 2'd2;
  end

  // Key matrix decode: '*' is backspace (E), '#' is blank-all (F).
  always_comb begin
    w_code = 4'h0;
    case ({r_row_idx, r_col_idx})
      4'b00_00: w_code = 4'h1;
      4'b00_01: w_code = 4'h2;
      4'b00_10: w_code = 4'h3;
      4'b00_11: w_code = 4'hA;
      4'b01_00: w_code = 4'h4;
      4'b01_01: w_code = 4'h5;
      4'b01_10: w_code = 4'h6;
      4'b01_11: w_code = 4'hB;
      4'b10_00: w_code = 4'h7;
      4'b10_01: w_code = 4'h8;
      4'b10_10: w_code = 4'h9;
      4'b10_11: w_code = 4'hC;
      4'b11_00: w_code = 4'hE;
      4'b11_01: w_code = 4'h0;
      4'b11_10: w_code = 4'hF;
      default:  w_code = 4'hD;
    endcase
  end

  // Scan/debounce/release FSM. State only changes on a tick, where the divider
  // is already being cleared, so every state change restarts the sample period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StScan;
      r_div       <= '0;
      r_cnt       <= '0;
      r_row       <= 4'b1110;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
    end else begin
      r_key_valid <= 1'b0;
      r_div       <= w_tick ? '0 : r_div + DivW'(1);
      if (w_tick) begin
        case (r_state)
          StScan: begin
            if (w_any_low) begin
              r_col_idx <= w_low_idx;
              r_cnt     <= CntW'(1);
              r_state   <= StDebounce;
            end else begin
              r_row     <= {r_row[2:0], r_row[3]};
              r_row_idx <= r_row_idx + 2'd1;
            end
          end
          StDebounce: begin
            if (w_same_low) begin
              if (w_cnt_done) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_code;
                r_cnt       <= '0;
                r_state     <= StRelease;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt     <= '0;
              r_state   <= StScan;
              r_row     <= {r_row[2:0], r_row[3]};
              r_row_idx <= r_row_idx + 2'd1;
            end
          end
          StRelease: begin
            if (col_in == 4'hF) begin
              if (w_cnt_done) begin
                r_cnt     <= '0;
                r_state   <= StScan;
                r_row     <= {r_row[2:0], r_row[3]};
                r_row_idx <= r_row_idx + 2'd1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: r_state <= StScan;
        endcase
      end
    end
  end

  // Message buffer; clear beats a coincident key.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_msg     <= Blank;
      r_msg_len <= 4'd0;
    end else if (w_accept) begin
      case (w_code)
        4'hE: begin
          if (r_msg_len != 4'd0) begin
            r_msg     <= {5'h1F, r_msg[49:5]};
            r_msg_len <= r_msg_len - 4'd1;
          end
        end
        4'hF: begin
          r_msg     <= Blank;
          r_msg_len <= 4'd0;
        end
        default: begin
          if (r_msg_len != 4'd10) begin
            r_msg     <= {r_msg[44:0], 1'b0, w_code};
            r_msg_len <= r_msg_len + 4'd1;
          end
        end
      endcase
    end
  end

  assign row_out   = r_row;
  assign msg       = r_msg;
  assign msg_len   = r_msg_len;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign full      = (r_msg_len == 4'd10);

endmodule
